// File: rtl/cpld_xorn_parity.sv
// Frame parity generator/checker. An optional registered stage computes the
// XOR of each data word. A two-state FSM folds those word parities into a
// frame accumulator, and a result stage presents Z0/ZV/ERR and the sticky ERRS.
module cpld_xorn_parity #(
    parameter int WIDTH = 8,
    parameter int ODD   = 0,
    parameter int PIPE  = 1
) (
    input  logic             CLK,
    input  logic             CDN,
    input  logic [WIDTH-1:0] A,
    input  logic             VLD,
    input  logic             SOF,
    input  logic             EOF,
    input  logic             PI,
    input  logic             CHK,
    input  logic             CLR,
    output logic             Z0,
    output logic             ZV,
    output logic             ERR,
    output logic             ERRS,
    output logic             BUSY
);

    typedef enum logic {IDLE, ACC} state_t;

    localparam logic ODD_BIT = (ODD != 0);

    logic   word_par;
    logic   s_pw, s_vld, s_sof, s_eof, s_pi, s_chk;
    state_t state_q, state_d;
    logic   acc_q, acc_d;
    logic   acc_new;
    logic   take;
    logic   res_v_q, res_v_d;
    logic   res_f_q, res_f_d;
    logic   res_pi_q, res_pi_d;
    logic   res_chk_q, res_chk_d;
    logic   mismatch;

    assign word_par = ^A;

    if (PIPE != 0) begin : g_pipe
        // Register the word parity together with its qualifiers.
        always_ff @(posedge CLK or negedge CDN) begin
            if (!CDN) begin
                s_pw  <= 1'b0;
                s_vld <= 1'b0;
                s_sof <= 1'b0;
                s_eof <= 1'b0;
                s_pi  <= 1'b0;
                s_chk <= 1'b0;
            end else begin
                s_pw  <= word_par;
                s_vld <= VLD;
                s_sof <= SOF;
                s_eof <= EOF;
                s_pi  <= PI;
                s_chk <= CHK;
            end
        end
    end else begin : g_comb
        // Feed the word parity and qualifiers straight through.
        always_comb begin
            s_pw  = word_par;
            s_vld = VLD;
            s_sof = SOF;
            s_eof = EOF;
            s_pi  = PI;
            s_chk = CHK;
        end
    end

    // Next-state logic: a SOF restarts the frame in either state (aborting an
    // open frame), other words only accumulate while a frame is open.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        res_v_d   = 1'b0;
        res_f_d   = res_f_q;
        res_pi_d  = res_pi_q;
        res_chk_d = res_chk_q;
        acc_new   = s_sof ? s_pw : (acc_q ^ s_pw);
        take      = s_vld && (s_sof || (state_q == ACC));
        if (take) begin
            acc_d = acc_new;
            if (s_eof) begin
                state_d   = IDLE;
                res_v_d   = 1'b1;
                res_f_d   = acc_new ^ ODD_BIT;
                res_pi_d  = s_pi;
                res_chk_d = s_chk;
            end else begin
                state_d = ACC;
            end
        end
    end

    // FSM state, accumulator and pending-result registers.
    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            state_q   <= IDLE;
            acc_q     <= 1'b0;
            res_v_q   <= 1'b0;
            res_f_q   <= 1'b0;
            res_pi_q  <= 1'b0;
            res_chk_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            res_v_q   <= res_v_d;
            res_f_q   <= res_f_d;
            res_pi_q  <= res_pi_d;
            res_chk_q <= res_chk_d;
        end
    end

    assign mismatch = res_v_q && res_chk_q && (res_f_q != res_pi_q);

    // Result outputs; a new mismatch takes priority over CLR on the sticky flag.
    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            Z0   <= 1'b0;
            ZV   <= 1'b0;
            ERR  <= 1'b0;
            ERRS <= 1'b0;
        end else begin
            ZV  <= res_v_q;
            ERR <= mismatch;
            if (res_v_q) Z0 <= res_f_q;
            if (mismatch)  ERRS <= 1'b1;
            else if (CLR)  ERRS <= 1'b0;
        end
    end

    assign BUSY = (state_q == ACC);

endmodule

// File: tb/tb_cpld_xorn_parity.sv
// Bench for cpld_xorn_parity: three configurations share one stimulus stream,
// expected frame results are queued at drive time and matched against ZV.
module tb_cpld_xorn_parity;

    logic       CLK = 1'b0;
    logic       CDN = 1'b0;
    logic [7:0] a_bus = '0;
    logic       VLD = 1'b0, SOF = 1'b0, EOF = 1'b0, PI = 1'b0, CHK = 1'b0, CLR = 1'b0;
    logic [2:0] z0, zv, err, errs, busy;

    cpld_xorn_parity #(.WIDTH(8), .ODD(0), .PIPE(1)) u_even_p (
        .CLK(CLK), .CDN(CDN), .A(a_bus), .VLD(VLD), .SOF(SOF), .EOF(EOF),
        .PI(PI), .CHK(CHK), .CLR(CLR),
        .Z0(z0[0]), .ZV(zv[0]), .ERR(err[0]), .ERRS(errs[0]), .BUSY(busy[0]));

    cpld_xorn_parity #(.WIDTH(8), .ODD(1), .PIPE(1)) u_odd_p (
        .CLK(CLK), .CDN(CDN), .A(a_bus), .VLD(VLD), .SOF(SOF), .EOF(EOF),
        .PI(PI), .CHK(CHK), .CLR(CLR),
        .Z0(z0[1]), .ZV(zv[1]), .ERR(err[1]), .ERRS(errs[1]), .BUSY(busy[1]));

    cpld_xorn_parity #(.WIDTH(3), .ODD(0), .PIPE(0)) u_w3_c (
        .CLK(CLK), .CDN(CDN), .A(a_bus[2:0]), .VLD(VLD), .SOF(SOF), .EOF(EOF),
        .PI(PI), .CHK(CHK), .CLR(CLR),
        .Z0(z0[2]), .ZV(zv[2]), .ERR(err[2]), .ERRS(errs[2]), .BUSY(busy[2]));

    always #5 CLK = ~CLK;

    typedef struct {
        int id;
        int due;
        bit f;
        bit e;
    } sb_t;

    sb_t sbq[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    bit  m_busy[3];
    bit  m_acc[3];
    bit  exp_z0[3];
    bit  exp_errs[3];
    int  zv_cnt[3];

    function automatic logic [7:0] mask_of(int id);
        return (id == 2) ? 8'h07 : 8'hFF;
    endfunction

    function automatic bit odd_of(int id);
        return id == 1;
    endfunction

    function automatic int pipe_of(int id);
        return (id == 2) ? 0 : 1;
    endfunction

    always @(posedge CLK) cyc = cyc + 1;

    // Scoreboard monitor: after each edge, compare result outputs to the queue.
    always @(negedge CLK) begin
        if (CDN === 1'b1) begin
            for (int id = 0; id < 3; id++) begin
                int  idx;
                bit  hit;
                bit  ez;
                bit  ee;
                sb_t ent;
                idx = -1;
                foreach (sbq[i]) if (idx < 0 && sbq[i].id == id) idx = i;
                if (idx >= 0 && sbq[idx].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_zv dut%0d: no ZV at cycle %0d, required one", id, sbq[idx].due);
                    sbq.delete(idx);
                    idx = -1;
                    foreach (sbq[i]) if (idx < 0 && sbq[i].id == id) idx = i;
                end
                hit = (idx >= 0) && (sbq[idx].due == cyc);
                ez  = hit;
                ee  = 1'b0;
                if (hit) begin
                    ent = sbq[idx];
                    sbq.delete(idx);
                    exp_z0[id] = ent.f;
                    ee = ent.e;
                end
                if (hit && ee)   exp_errs[id] = 1'b1;
                else if (CLR)    exp_errs[id] = 1'b0;
                if (zv[id] === 1'b1) zv_cnt[id]++;
                checks++;
                if (zv[id] !== ez) begin
                    errors++;
                    $display("FAIL zv dut%0d cyc%0d: got %b, required %b", id, cyc, zv[id], ez);
                end
                checks++;
                if (z0[id] !== exp_z0[id]) begin
                    errors++;
                    $display("FAIL z0 dut%0d cyc%0d: got %b, required %b", id, cyc, z0[id], exp_z0[id]);
                end
                checks++;
                if (err[id] !== ee) begin
                    errors++;
                    $display("FAIL err dut%0d cyc%0d: got %b, required %b", id, cyc, err[id], ee);
                end
                checks++;
                if (errs[id] !== exp_errs[id]) begin
                    errors++;
                    $display("FAIL errs dut%0d cyc%0d: got %b, required %b", id, cyc, errs[id], exp_errs[id]);
                end
            end
        end
    end

    // Drive one word for the next edge and advance the reference frame model.
    task automatic step(input logic [7:0] a, input bit v, input bit s, input bit e,
                        input bit p, input bit c, input bit cl);
        @(negedge CLK);
        #1;
        a_bus = a; VLD = v; SOF = s; EOF = e; PI = p; CHK = c; CLR = cl;
        for (int id = 0; id < 3; id++) begin
            bit pw;
            bit nacc;
            bit f;
            sb_t ent;
            pw = ^(a & mask_of(id));
            if (v && (s || m_busy[id])) begin
                nacc = s ? pw : (m_acc[id] ^ pw);
                m_acc[id] = nacc;
                if (e) begin
                    f = nacc ^ odd_of(id);
                    ent.id  = id;
                    ent.due = cyc + 2 + pipe_of(id);
                    ent.f   = f;
                    ent.e   = c && (f != p);
                    sbq.push_back(ent);
                    m_busy[id] = 1'b0;
                end else begin
                    m_busy[id] = 1'b1;
                end
            end
        end
    endtask

    task automatic drain(input int n);
        repeat (n) step(8'h00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic clear_model();
        sbq.delete();
        for (int id = 0; id < 3; id++) begin
            m_busy[id] = 1'b0;
            m_acc[id] = 1'b0;
            exp_z0[id] = 1'b0;
            exp_errs[id] = 1'b0;
        end
    endtask

    task automatic test_reset();
        clear_model();
        #3;
        for (int id = 0; id < 3; id++) begin
            checks++;
            if ({z0[id], zv[id], err[id], errs[id], busy[id]} !== 5'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %b, required 00000", id,
                         {z0[id], zv[id], err[id], errs[id], busy[id]});
            end
        end
        @(negedge CLK);
        #1 CDN = 1'b1;
    endtask

    task automatic test_basic();
        int c0[3];
        for (int id = 0; id < 3; id++) c0[id] = zv_cnt[id];
        step(8'h01, 1, 1, 0, 0, 0, 0);
        step(8'h03, 1, 0, 0, 0, 0, 0);
        step(8'h07, 1, 0, 1, 0, 0, 0);
        drain(4);
        checks++;
        if (z0 !== 3'b010) begin
            errors++;
            $display("FAIL basic_z0: got %b, required 010", z0);
        end
        for (int id = 0; id < 3; id++) begin
            checks++;
            if (zv_cnt[id] - c0[id] != 1) begin
                errors++;
                $display("FAIL basic_zv_count dut%0d: got %0d, required 1", id, zv_cnt[id] - c0[id]);
            end
        end
    endtask

    task automatic test_single_err();
        step(8'hFF, 1, 1, 1, 0, 1, 0);
        drain(4);
        checks++;
        if (z0 !== 3'b110) begin
            errors++;
            $display("FAIL single_z0: got %b, required 110", z0);
        end
        checks++;
        if (errs !== 3'b110) begin
            errors++;
            $display("FAIL single_errs: got %b, required 110", errs);
        end
        step(8'h00, 0, 0, 0, 0, 0, 1);
        step(8'h00, 0, 0, 0, 0, 0, 0);
        checks++;
        if (errs !== 3'b000) begin
            errors++;
            $display("FAIL clr_errs: got %b, required 000", errs);
        end
    endtask

    task automatic test_gap();
        step(8'h04, 1, 1, 0, 0, 0, 0);
        for (int g = 0; g < 3; g++) begin
            step(8'h00, 0, 0, 0, 0, 0, 0);
            checks++;
            if (busy[2] !== 1'b1) begin
                errors++;
                $display("FAIL gap_busy gap%0d: got %b, required 1", g, busy[2]);
            end
        end
        checks++;
        if (busy !== 3'b111) begin
            errors++;
            $display("FAIL gap_busy_all: got %b, required 111", busy);
        end
        step(8'h07, 1, 0, 1, 0, 0, 0);
        step(8'h00, 0, 0, 0, 0, 0, 0);
        checks++;
        if (busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL gap_busy_end: got %b, required 0", busy[2]);
        end
        step(8'h00, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({zv[2], z0[2]} !== 2'b10) begin
            errors++;
            $display("FAIL gap_result zv,z0: got %b, required 10", {zv[2], z0[2]});
        end
        drain(3);
    endtask

    task automatic test_abort();
        int c0;
        c0 = zv_cnt[0];
        step(8'h01, 1, 1, 0, 0, 0, 0);
        step(8'h02, 1, 1, 0, 0, 0, 0);
        step(8'h02, 1, 0, 1, 0, 0, 0);
        drain(4);
        checks++;
        if (zv_cnt[0] - c0 != 1) begin
            errors++;
            $display("FAIL abort_zv_count: got %0d, required 1", zv_cnt[0] - c0);
        end
        checks++;
        if (z0[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_z0: got %b, required 0", z0[0]);
        end
    endtask

    task automatic test_back_to_back();
        int c0[3];
        for (int id = 0; id < 3; id++) c0[id] = zv_cnt[id];
        step(8'h03, 1, 1, 1, 1, 1, 0);
        step(8'h10, 1, 1, 0, 0, 0, 0);
        step(8'h30, 1, 0, 1, 1, 1, 0);
        step(8'h7F, 1, 1, 1, 0, 0, 0);
        drain(4);
        for (int id = 0; id < 3; id++) begin
            checks++;
            if (zv_cnt[id] - c0[id] != 3) begin
                errors++;
                $display("FAIL b2b_zv_count dut%0d: got %0d, required 3", id, zv_cnt[id] - c0[id]);
            end
        end
        step(8'h00, 0, 0, 0, 0, 0, 1);
        drain(1);
    endtask

    task automatic test_clr_collide();
        step(8'h01, 1, 1, 1, 0, 1, 0);
        step(8'h00, 0, 0, 0, 0, 0, 1);
        step(8'h00, 0, 0, 0, 0, 0, 1);
        checks++;
        if (errs[2] !== 1'b1) begin
            errors++;
            $display("FAIL collide_errs dut2: got %b, required 1", errs[2]);
        end
        step(8'h00, 0, 0, 0, 0, 0, 0);
        checks++;
        if (errs !== 3'b001) begin
            errors++;
            $display("FAIL collide_errs_all: got %b, required 001", errs);
        end
        drain(2);
    endtask

    task automatic test_reset_midframe();
        int c0[3];
        step(8'h05, 1, 1, 0, 0, 0, 0);
        step(8'h00, 0, 0, 0, 0, 0, 0);
        step(8'h00, 0, 0, 0, 0, 0, 0);
        checks++;
        if (busy !== 3'b111) begin
            errors++;
            $display("FAIL midframe_busy: got %b, required 111", busy);
        end
        @(negedge CLK);
        #2;
        CDN = 1'b0;
        VLD = 1'b0;
        clear_model();
        #1;
        for (int id = 0; id < 3; id++) begin
            checks++;
            if ({z0[id], zv[id], err[id], errs[id], busy[id]} !== 5'b0) begin
                errors++;
                $display("FAIL midframe_reset dut%0d: got %b, required 00000", id,
                         {z0[id], zv[id], err[id], errs[id], busy[id]});
            end
        end
        @(negedge CLK);
        #1 CDN = 1'b1;
        for (int id = 0; id < 3; id++) c0[id] = zv_cnt[id];
        step(8'h06, 1, 0, 1, 0, 1, 0);
        drain(4);
        for (int id = 0; id < 3; id++) begin
            checks++;
            if (zv_cnt[id] != c0[id]) begin
                errors++;
                $display("FAIL post_reset_zv dut%0d: got %0d pulses, required 0", id, zv_cnt[id] - c0[id]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int id = 0; id < 3; id++) zv_cnt[id] = 0;
        test_reset();
        test_basic();
        test_single_err();
        test_gap();
        test_abort();
        test_back_to_back();
        test_clr_collide();
        test_reset_midframe();
        drain(2);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL leftover_results: got %0d pending, required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpld_xorn_parity.md
CPLD_XORN_PARITY -- requirements
Module: cpld_xorn_parity

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width; legal range 2..32.
REQ-002 The block SHALL have parameter ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 The block SHALL have parameter PIPE, default 1: 1 adds a registered word-reduction stage, 0 reduces combinationally.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port CDN, input, 1 bit: asynchronous active-low clear of all state.
REQ-006 The block SHALL have port A, input, WIDTH bits: data word.
REQ-007 The block SHALL have port VLD, input, 1 bit: A, SOF, EOF and PI are valid this cycle.
REQ-008 The block SHALL have port SOF, input, 1 bit: first word of frame, qualified by VLD.
REQ-009 The block SHALL have port EOF, input, 1 bit: last word of frame, qualified by VLD.
REQ-010 The block SHALL have port PI, input, 1 bit: received parity bit, sampled only on the EOF word.
REQ-011 The block SHALL have port CHK, input, 1 bit: 1 selects check mode, 0 selects generate mode; sampled on the EOF word.
REQ-012 The block SHALL have port CLR, input, 1 bit: synchronous clear of ERRS.
REQ-013 The block SHALL have port Z0, output, 1 bit: frame parity result, held until the next result.
REQ-014 The block SHALL have port ZV, output, 1 bit: one-cycle pulse marking Z0 and ERR valid.
REQ-015 The block SHALL have port ERR, output, 1 bit: one-cycle mismatch pulse, asserted only with ZV in check mode.
REQ-016 The block SHALL have port ERRS, output, 1 bit: sticky mismatch flag.
REQ-017 The block SHALL have port BUSY, output, 1 bit: high while a frame is open (state ACC).

Function
REQ-018 The word parity SHALL be pw = XOR of A[WIDTH-1:0], registered together with VLD/SOF/EOF/PI/CHK when PIPE=1.
REQ-019 The block SHALL implement a two-state FSM: IDLE (no frame open) and ACC (frame open).
REQ-020 A word with VLD=1 and SOF=1 SHALL load acc := pw in any state and enter ACC; a frame already open is aborted with no result.
REQ-021 A word with VLD=1, SOF=0 in state ACC SHALL update acc := acc ^ pw.
REQ-022 A word with VLD=1, SOF=0 in state IDLE SHALL be ignored, with no state or output change.
REQ-023 An EOF word (VLD=1, EOF=1, in ACC or carrying SOF) SHALL set the final parity f = acc_new ^ ODD and return the FSM to IDLE.
REQ-024 SOF=1 and EOF=1 on the same word SHALL form a single-word frame with f = pw ^ ODD.
REQ-025 The block SHALL set Z0 = f and pulse ZV on the edge PIPE+1 cycles after the EOF word edge; latency SHALL be 1 cycle with PIPE=0 and 2 cycles with PIPE=1.
REQ-026 In check mode, ERR SHALL pulse with ZV when f != PI, and ERRS SHALL set on the same edge.
REQ-027 In generate mode, ERR SHALL stay 0 and ERRS SHALL be unaffected.
REQ-028 CLR=1 SHALL clear ERRS on the next edge; if CLR coincides with a new ERR, set SHALL win.
REQ-029 Cycles with VLD=0 SHALL leave acc, the FSM state and Z0 unchanged; gaps inside a frame are legal.
REQ-030 Back-to-back frames SHALL be supported: a SOF on the cycle after an EOF is accepted with no bubble.

Reset
REQ-031 CDN low SHALL asynchronously force Z0=0, ZV=0, ERR=0, ERRS=0, BUSY=0, acc=0, FSM=IDLE and clear the pipeline registers, including mid-frame.
REQ-032 After CDN deasserts, the first accepted word SHALL be a SOF word; earlier non-SOF words are ignored per REQ-022.

Verification
REQ-033 WIDTH=8, ODD=0, PIPE=1: words 0x01, 0x03, 0x07 (SOF on the first word, EOF on the last), CHK=0 -> ZV pulses 2 cycles after EOF with Z0=0 (parities 1^0^1).
REQ-034 WIDTH=8, ODD=1: single word 0xFF with SOF=EOF=1, CHK=1, PI=0 -> Z0=1, ERR=1, ERRS=1; a later CLR=1 -> ERRS=0.
REQ-035 WIDTH=3, PIPE=0: frame {A=3'b100 SOF, gap VLD=0 for 3 cycles, A=3'b111 EOF} -> Z0=0 one cycle after EOF; BUSY stays high through the gap.
REQ-036 Frame 0x01 SOF, then 0x02 SOF, then 0x02 EOF -> exactly one ZV, with Z0=0 (first frame aborted).
REQ-037 CDN pulsed low mid-frame -> all outputs 0 immediately; a following non-SOF EOF word produces no ZV.
REQ-038 CLR=1 coincident with an ERR pulse -> ERRS=1 after the edge.
